// File: rtl/cla_pkg.sv
// Shared constants and stage-geometry helpers for the pipelined carry-look-ahead adder.
package cla_pkg;

  localparam int unsigned CLA_WIDTH_DEF = 16;
  localparam int unsigned CLA_GROUP_DEF = 4;

  function automatic int unsigned cla_nstg(input int unsigned width, input int unsigned group);
    return (group == 0) ? 0 : width / group;
  endfunction

  // Bit offset of stage k's operand skew slice inside the packed skew vector.
  function automatic int unsigned cla_skew_off(input int unsigned width, input int unsigned group,
                                               input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) off += width - (j + 1) * group;
    return off;
  endfunction

  // Bit offset of stage k's completed-sum slice inside the packed de-skew vector.
  function automatic int unsigned cla_dskw_off(input int unsigned group, input int unsigned k);
    return group * k * (k + 1) / 2;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One combinational GROUP-bit carry-look-ahead block with group generate/propagate.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             g,
  output logic             p,
  output logic             co
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] c;
  logic             gacc;
  logic             pacc;

  // Every internal carry is formed from prefix generate/propagate terms and ci.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i] = gacc | (pacc & ci);
      gacc = gen[i] | (prop[i] & gacc);
      pacc = pacc & prop[i];
    end
    s  = prop ^ c;
    g  = gacc;
    p  = pacc;
    co = gacc | (pacc & ci);
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder: one look-ahead group per stage with operand skew and sum de-skew.
// Define PIPELINED_CLA_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH_DEF,
  parameter int unsigned GROUP = CLA_GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSTG      = cla_nstg(WIDTH, GROUP);
  localparam int unsigned SKEW_BITS = (NSTG > 1) ? cla_skew_off(WIDTH, GROUP, NSTG - 1) : 1;
  localparam int unsigned DSKW_BITS = cla_dskw_off(GROUP, NSTG);

  if (GROUP == 0 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  logic [NSTG-1:0]      v_q, v_d;
  logic [NSTG-1:0]      c_q, c_d;
  logic [SKEW_BITS-1:0] a_sk_q, a_sk_d;
  logic [SKEW_BITS-1:0] b_sk_q, b_sk_d;
  logic [DSKW_BITS-1:0] s_dk_q, s_dk_d;
  logic                 advance;
`ifdef PIPELINED_CLA_OVERFLOW_EN
  logic                 ovf_q, ovf_d;
`endif

  if (NSTG == 1) begin : g_no_skew
    assign a_sk_d = '0;
    assign b_sk_d = '0;
  end

  // Stage k's unconsumed operands and finished sum bits live in packed per-stage slices.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned REM  = WIDTH - (k + 1) * GROUP;
    localparam int unsigned DONE = (k + 1) * GROUP;
    localparam int unsigned DOFF = cla_dskw_off(GROUP, k);

    logic [GROUP-1:0] ga, gb, gs;
    logic             gci, gg, gp, gco;

    if (k == 0) begin : g_src_port
      assign ga = a[GROUP-1:0];
      assign gb = b[GROUP-1:0];
      assign gci = cin;
      if (REM > 0) begin : g_fwd
        assign a_sk_d[0 +: REM] = a[WIDTH-1:GROUP];
        assign b_sk_d[0 +: REM] = b[WIDTH-1:GROUP];
      end
      assign s_dk_d[DOFF +: DONE] = gs;
      assign v_d[k] = in_valid;
    end else begin : g_src_stage
      localparam int unsigned POFF  = cla_skew_off(WIDTH, GROUP, k - 1);
      localparam int unsigned PDOFF = cla_dskw_off(GROUP, k - 1);
      assign ga = a_sk_q[POFF +: GROUP];
      assign gb = b_sk_q[POFF +: GROUP];
      assign gci = c_q[k-1];
      if (REM > 0) begin : g_fwd
        localparam int unsigned OFF = cla_skew_off(WIDTH, GROUP, k);
        assign a_sk_d[OFF +: REM] = a_sk_q[POFF + GROUP +: REM];
        assign b_sk_d[OFF +: REM] = b_sk_q[POFF + GROUP +: REM];
      end
      assign s_dk_d[DOFF +: DONE] = {gs, s_dk_q[PDOFF +: k * GROUP]};
      assign v_d[k] = v_q[k-1];
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a (ga),
      .b (gb),
      .ci(gci),
      .s (gs),
      .g (gg),
      .p (gp),
      .co(gco)
    );

    assign c_d[k] = gco;

    always_comb begin
      assert (gco == (gg | (gp & gci)));
    end

`ifdef PIPELINED_CLA_OVERFLOW_EN
    if (k == NSTG - 1) begin : g_ovf
      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign ovf_d = gco ^ (ga[GROUP-1] ^ gb[GROUP-1] ^ gs[GROUP-1]);
    end
`endif
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      a_sk_q <= '0;
      b_sk_q <= '0;
      s_dk_q <= '0;
`ifdef PIPELINED_CLA_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else if (advance) begin
      v_q    <= v_d;
      c_q    <= c_d;
      a_sk_q <= a_sk_d;
      b_sk_q <= b_sk_d;
      s_dk_q <= s_dk_d;
`ifdef PIPELINED_CLA_OVERFLOW_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign sum       = s_dk_q[DSKW_BITS-1 -: WIDTH];
`ifdef PIPELINED_CLA_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Random and directed checks of pipelined_cla_adder (WIDTH=16, GROUP=4) against an arithmetic model.
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPELINED_CLA_OVERFLOW_EN
  logic        ovf;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_out = 0;
  int unsigned streak = 0;
  int unsigned max_streak = 0;
  logic [17:0] exp_q[$];
  logic        hold = 1'b0;
  logic [17:0] prev_obs;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef PIPELINED_CLA_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {signed overflow, 17-bit arithmetic sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'd0, c};
`ifdef PIPELINED_CLA_OVERFLOW_EN
    v = (x[15] == y[15]) && (t[15] != x[15]);
`else
    v = 1'b0;
`endif
    return {v, t};
  endfunction

  function automatic logic [17:0] observed();
`ifdef PIPELINED_CLA_OVERFLOW_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !out_valid || out_ready});
      if (hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, observed()}, {14'd0, prev_obs});
      end
      if (out_valid && out_ready) begin
        n_out++;
        streak++;
        if (streak > max_streak) max_streak = streak;
        if (exp_q.size() == 0) check("spurious_out", {31'd0, out_valid}, 32'd0);
        else check("result", {14'd0, observed()}, {14'd0, exp_q.pop_front()});
      end else begin
        streak = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      hold     = out_valid && !out_ready;
      prev_obs = observed();
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic ok;
    ok = 1'b0;
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned lat;
    int unsigned base;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_sum", {15'd0, cout, sum}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Latency
    send(16'h0001, 16'h0002, 1'b0);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (out_valid) lat = n;
    end
    check("latency", lat, 32'd4);
    check("latency_sum", {15'd0, cout, sum}, 32'h0000_0003);
    idle(6);

    // Full carry ripple and overflow corners
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'hFFFE, 16'hFFFF, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    idle(8);

    // Back-pressure
    base = n_out;
    send(16'h0003, 16'h0004, 1'b0);
    send(16'h0005, 16'h0006, 1'b0);
    send(16'h000E, 16'h000F, 1'b0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_sum", {15'd0, cout, sum}, 32'h0000_0007);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(8);
    check("bp_count", n_out - base, 32'd3);

    // Throughput
    base = n_out;
    max_streak = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    idle(8);
    check("tput_count", n_out - base, 32'd64);
    check("tput_streak", max_streak, 32'd64);

    // Random valid/ready mix
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(10);

    // Reset mid-stream with three in flight
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_sum", {15'd0, cout, sum}, 32'd0);
    exp_q.delete();
    base = n_out;
    @(posedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    idle(10);
    check("no_ghost_results", n_out - base, 32'd0);
    check("model_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
